// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the LC3 fetch-control sequencer: opcode values,
// sequencer states and the instruction classes the sequencer reacts to.
package fetch_ctrl_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_RESOLVE  = 3'd2,
    S_REDIRECT = 3'd3,
    S_MEM      = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  // C_MEM2 marks indirect accesses that need two completed memory transfers.
  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_CTRL = 3'd1,
    C_MEM1 = 3'd2,
    C_MEM2 = 3'd3,
    C_TRAP = 3'd4
  } op_class_t;

endpackage

// File: rtl/fetch_ctrl_seq_opclass.sv
// Combinational instruction classifier. Takes the opcode and BR condition
// field (instruction bits [15:9]) and reports how the sequencer must stall.
module fetch_ctrl_opclass
  import fetch_ctrl_pkg::*;
(
  input  logic [6:0] instr_hi,
  output op_class_t  op_class
);

  logic [3:0] opcode;
  logic [2:0] nzp;

  assign opcode = instr_hi[6:3];
  assign nzp    = instr_hi[2:0];

  // A BR with an empty condition field never redirects, so it is a plain NOP.
  always_comb begin
    op_class = C_NONE;
    case (opcode)
      OP_BR:                       op_class = (nzp != 3'b000) ? C_CTRL : C_NONE;
      OP_JMP, OP_JSR:              op_class = C_CTRL;
      OP_LD, OP_LDR, OP_ST, OP_STR: op_class = C_MEM1;
      OP_LDI, OP_STI:              op_class = C_MEM2;
      OP_TRAP:                     op_class = C_TRAP;
      default:                     op_class = C_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl_seq.sv
// Fetch-control sequencer: Moore FSM that gates the LC3 fetch stage, stalls
// for memory and control-flow instructions, and issues one-cycle redirects.
module fetch_ctrl_seq
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int RESOLVE_LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_dout,
  input  logic [2:0]         psr_nzp,
  input  logic [ADDR_W-1:0]  exec_taddr,
  input  logic               mem_done,
  output logic               br_taken,
  output logic [ADDR_W-1:0]  taddr,
  output logic               enable_updatePC,
  output logic               enable_fetch,
  output logic               halted
);

  if (RESOLVE_LAT < 1) begin : g_bad_resolve_lat
    $error("fetch_ctrl_seq: RESOLVE_LAT must be at least 1");
  end

  localparam int CNT_W = $clog2(RESOLVE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RESOLVE = CNT_W'(RESOLVE_LAT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   taddr_q, taddr_d;
  logic [2:0]          nzp_q, nzp_d;
  logic                jump_q, jump_d;

  op_class_t           op_class;
  logic [3:0]          opcode;
  logic                unused_instr_bits;

  assign opcode            = instr_dout[15:12];
  assign unused_instr_bits = ^instr_dout[8:0];

  fetch_ctrl_opclass u_opclass (
    .instr_hi (instr_dout[15:9]),
    .op_class (op_class)
  );

  // Next-state logic: instructions are sampled only in S_FETCH, and the
  // redirect decision (and its target) is taken only on the last resolve cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    taddr_d = taddr_q;
    nzp_d   = nzp_q;
    jump_d  = jump_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          case (op_class)
            C_CTRL: begin
              state_d = S_RESOLVE;
              cnt_d   = CNT_RESOLVE;
              jump_d  = (opcode != OP_BR);
              if (opcode == OP_BR) nzp_d = instr_dout[11:9];
            end
            C_MEM1: begin
              state_d = S_MEM;
              cnt_d   = CNT_ZERO;
            end
            C_MEM2: begin
              state_d = S_MEM;
              cnt_d   = CNT_ONE;
            end
            C_TRAP:  state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_RESOLVE: begin
        if (cnt_q == CNT_ZERO) begin
          if (jump_q || (|(nzp_q & psr_nzp))) begin
            state_d = S_REDIRECT;
            taddr_d = exec_taddr;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_REDIRECT: state_d = S_FETCH;
      S_MEM: begin
        if (mem_done) begin
          if (cnt_q == CNT_ZERO) state_d = S_FETCH;
          else                   cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any pending redirect or memory access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      taddr_q <= '0;
      nzp_q   <= 3'b000;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taddr_q <= taddr_d;
      nzp_q   <= nzp_d;
      jump_q  <= jump_d;
    end
  end

  assign enable_fetch    = (state_q == S_FETCH);
  assign enable_updatePC = (state_q == S_FETCH) || (state_q == S_REDIRECT);
  assign br_taken        = (state_q == S_REDIRECT);
  assign halted          = (state_q == S_HALT);
  assign taddr           = taddr_q;

endmodule

// File: tb/tb_fetch_ctrl_seq.sv
// Directed, table-driven bench for fetch_ctrl_seq (RESOLVE_LAT = 2).
module tb_fetch_ctrl_seq;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr_dout;
  logic [2:0]  psr_nzp;
  logic [15:0] exec_taddr;
  logic        mem_done;
  logic        br_taken;
  logic [15:0] taddr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [2:0]  psr;
    logic [15:0] exec;
    logic        md;
    logic        exp_br;
    logic [15:0] exp_taddr;
    logic        exp_upd;
    logic        exp_fetch;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[$];

  fetch_ctrl_seq #(.ADDR_W(16), .INSTR_W(16), .RESOLVE_LAT(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_dout      (instr_dout),
    .psr_nzp         (psr_nzp),
    .exec_taddr      (exec_taddr),
    .mem_done        (mem_done),
    .br_taken        (br_taken),
    .taddr           (taddr),
    .enable_updatePC (enable_updatePC),
    .enable_fetch    (enable_fetch),
    .halted          (halted)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic v, input logic [15:0] i, input logic [2:0] p,
                              input logic [15:0] e, input logic m, input logic br,
                              input logic [15:0] ta, input logic upd, input logic fe,
                              input logic hl);
    vec_t r;
    r.valid = v; r.instr = i; r.psr = p; r.exec = e; r.md = m;
    r.exp_br = br; r.exp_taddr = ta; r.exp_upd = upd; r.exp_fetch = fe; r.exp_halt = hl;
    return r;
  endfunction

  // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input vec_t v);
    instr_valid = v.valid;
    instr_dout  = v.instr;
    psr_nzp     = v.psr;
    exec_taddr  = v.exec;
    mem_done    = v.md;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic br, input logic [15:0] ta,
                             input logic upd, input logic fe, input logic hl);
    logic [19:0] got, want;
    got  = {br_taken, taddr, enable_updatePC, enable_fetch, halted};
    want = {br, ta, upd, fe, hl};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got br=%b taddr=%h upd=%b fetch=%b halt=%b, expected br=%b taddr=%h upd=%b fetch=%b halt=%b",
               name, br_taken, taddr, enable_updatePC, enable_fetch, halted, br, ta, upd, fe, hl);
    end
  endtask

  initial begin
    vec_t idle;
    // ADD: ordinary instruction keeps fetching
    vecs.push_back(mk(1, 16'h1261, 3'b000, 16'h0000, 0,  0, 16'h0000, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h0000, 1, 1, 0));
    // BRz taken: 2 stall cycles, 1 redirect cycle, then fetch
    vecs.push_back(mk(1, 16'h0402, 3'b010, 16'h3010, 0,  0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b010, 16'h3010, 0,  0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b010, 16'h3010, 0,  1, 16'h3010, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b010, 16'h3010, 0,  0, 16'h3010, 1, 1, 0));
    // BRz not taken: 2 stall cycles, taddr keeps old value
    vecs.push_back(mk(1, 16'h0402, 3'b100, 16'h4444, 0,  0, 16'h3010, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b100, 16'h4444, 0,  0, 16'h3010, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b100, 16'h4444, 0,  0, 16'h3010, 1, 1, 0));
    // JMP: always taken regardless of condition codes
    vecs.push_back(mk(1, 16'hC1C0, 3'b000, 16'h5000, 0,  0, 16'h3010, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h5000, 0,  0, 16'h3010, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h5000, 0,  1, 16'h5000, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h5000, 1, 1, 0));
    // JSR, with a TRAP offered during the stall that must be ignored
    vecs.push_back(mk(1, 16'h4800, 3'b000, 16'h6000, 0,  0, 16'h5000, 0, 0, 0));
    vecs.push_back(mk(1, 16'hF025, 3'b000, 16'h6000, 0,  0, 16'h5000, 0, 0, 0));
    vecs.push_back(mk(1, 16'hF025, 3'b000, 16'h6000, 0,  1, 16'h6000, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 1, 1, 0));
    // BR with nzp=000 is a NOP
    vecs.push_back(mk(1, 16'h0005, 3'b111, 16'h7000, 0,  0, 16'h6000, 1, 1, 0));
    // LDI: two mem_done pulses four cycles apart
    vecs.push_back(mk(1, 16'hA201, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 1,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 1,  0, 16'h6000, 1, 1, 0));
    // stray mem_done in fetch is ignored
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 1,  0, 16'h6000, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 1, 1, 0));
    // LD: single pulse resumes fetch
    vecs.push_back(mk(1, 16'h2001, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 1,  0, 16'h6000, 1, 1, 0));
    // TRAP: frozen regardless of further activity
    vecs.push_back(mk(1, 16'hF025, 3'b000, 16'h0000, 0,  0, 16'h6000, 0, 0, 1));
    vecs.push_back(mk(1, 16'h1261, 3'b111, 16'h1234, 1,  0, 16'h6000, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0402, 3'b010, 16'h1234, 0,  0, 16'h6000, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 3'b000, 16'h0000, 1,  0, 16'h6000, 0, 0, 1));

    idle = mk(0, 16'h0000, 3'b000, 16'h0000, 0,  0, 16'h0000, 0, 0, 0);

    // Reset held for three cycles
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle);
      checkOutput("reset_hold", 0, 16'h0000, 0, 0, 0);
    end
    reset = 1'b0;
    #1;
    checkOutput("idle_after_release", 0, 16'h0000, 0, 0, 0);
    applyStimulus(idle);
    checkOutput("first_fetch", 0, 16'h0000, 1, 1, 0);

    // Table-driven main sequence
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_br, vecs[i].exp_taddr,
                  vecs[i].exp_upd, vecs[i].exp_fetch, vecs[i].exp_halt);
    end

    // Reset out of halt gives a clean restart
    reset = 1'b1;
    applyStimulus(idle);
    checkOutput("halt_reset", 0, 16'h0000, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(idle);
    checkOutput("halt_restart", 0, 16'h0000, 1, 1, 0);

    // Reset during resolve discards the pending redirect
    applyStimulus(mk(1, 16'h0402, 3'b010, 16'h7777, 0,  0, 16'h0000, 0, 0, 0));
    checkOutput("resolve_enter", 0, 16'h0000, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(mk(0, 16'h0000, 3'b010, 16'h7777, 0,  0, 16'h0000, 0, 0, 0));
    checkOutput("resolve_reset", 0, 16'h0000, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(mk(0, 16'h0000, 3'b010, 16'h7777, 0,  0, 16'h0000, 0, 0, 0));
    checkOutput("resolve_no_redirect1", 0, 16'h0000, 1, 1, 0);
    applyStimulus(mk(0, 16'h0000, 3'b010, 16'h7777, 0,  0, 16'h0000, 0, 0, 0));
    checkOutput("resolve_no_redirect2", 0, 16'h0000, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
